// File: rtl/decode_issue_if.sv
// ---------------------------------------------------------------------------
// decode_issue_if
//   Groups the signals of the BRISC decode/issue stage: the fetch-side
//   handshake, the held decoded instruction toward execute, the register
//   file read addresses, writeback retirement, flush and status.
//
//   Modports:
//     slave  - the decode/issue stage itself.
//     master - the environment around it (fetch, execute, writeback).
//
//   Signals:
//     in_valid, in_instr[15:0], in_ready  fetch handshake
//     out_valid, out_ready                execute handshake
//     out_op[3:0], out_rd[3:0], out_imm[7:0], out_we
//                                         held decoded instruction
//     rega_addr[3:0], regb_addr[3:0]      register-file read addresses
//     wb_valid, wb_addr[3:0]              retiring write
//     flush                               discard held instruction
//     illegal                             illegal-opcode pulse
//     busy                                any scoreboard bit pending
// ---------------------------------------------------------------------------
interface decode_issue_if;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [3:0]  out_rd;
  logic [3:0]  rega_addr;
  logic [3:0]  regb_addr;
  logic [7:0]  out_imm;
  logic        out_we;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic        flush;
  logic        illegal;
  logic        busy;

  modport slave (
    input  in_valid, in_instr, out_ready, wb_valid, wb_addr, flush,
    output in_ready, out_valid, out_op, out_rd, rega_addr, regb_addr,
           out_imm, out_we, illegal, busy
  );

  modport master (
    output in_valid, in_instr, out_ready, wb_valid, wb_addr, flush,
    input  in_ready, out_valid, out_op, out_rd, rega_addr, regb_addr,
           out_imm, out_we, illegal, busy
  );
endinterface

// File: rtl/decode_issue.sv
// ---------------------------------------------------------------------------
// decode_issue
//   Decode/issue stage of the 16-bit BRISC core. Decodes one instruction
//   per cycle from fetch into a single output register held for execute,
//   drives the register-file read addresses, and tracks in-flight
//   destination registers in a scoreboard so RAW/WAW dependent
//   instructions stall until writeback retires the conflicting write.
//
//   Ports:
//     clk    - system clock, rising edge
//     rst_n  - synchronous active-low reset
//     bus    - decode_issue_if.slave (handshakes, decoded fields,
//              writeback, flush, illegal, busy)
//
//   Parameters:
//     NREGS          - architectural registers / scoreboard depth
//                      (register addresses are always 4 bits)
//     ILLEGAL_AS_NOP - 1: opcodes 0xC-0xF issue as NOP and pulse illegal
//                      0: such an opcode stalls forever (debug aid)
//
//   Build option:
//     DECODE_WB_BYPASS_EN - when defined, a scoreboard bit being cleared by
//                           writeback this cycle is treated as not pending,
//                           so a dependent instruction issues in the same
//                           cycle as the retiring write.
// ---------------------------------------------------------------------------
module decode_issue #(
  parameter int NREGS          = 16,
  parameter int ILLEGAL_AS_NOP = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  decode_issue_if.slave  bus
);

  // Instruction fields
  logic [3:0] f_op, f_rd, f_ra, f_rb;
  logic [7:0] f_imm;

  // Decode class
  logic reads_a, reads_b, writes, is_illegal;

  // Hazard / handshake
  logic [NREGS-1:0] wb_mask;
  logic [NREGS-1:0] sb_pend;
  logic             hazard;
  logic             in_ready;
  logic             accept;

  // State
  logic             out_valid_q, out_valid_d;
  logic [3:0]       out_op_q,    out_op_d;
  logic [3:0]       out_rd_q,    out_rd_d;
  logic [3:0]       rega_q,      rega_d;
  logic [3:0]       regb_q,      regb_d;
  logic [7:0]       out_imm_q,   out_imm_d;
  logic             out_we_q,    out_we_d;
  logic             illegal_q,   illegal_d;
  logic [NREGS-1:0] sb_q,        sb_d;

  assign f_op  = bus.in_instr[15:12];
  assign f_rd  = bus.in_instr[11:8];
  assign f_ra  = bus.in_instr[7:4];
  assign f_rb  = bus.in_instr[3:0];
  assign f_imm = bus.in_instr[7:0];

  // Decode: which register fields the opcode reads and whether it writes rd.
  always_comb begin
    reads_a    = 1'b0;
    reads_b    = 1'b0;
    writes     = 1'b0;
    is_illegal = 1'b0;
    case (f_op)
      4'h0: ;
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
        reads_a = 1'b1;
        reads_b = 1'b1;
        writes  = 1'b1;
      end
      4'h8: writes = 1'b1;
      4'h9: begin
        reads_a = 1'b1;
        writes  = 1'b1;
      end
      4'hA, 4'hB: begin
        reads_a = 1'b1;
        reads_b = 1'b1;
      end
      default: is_illegal = 1'b1;
    endcase
  end

  // One-hot of the register being retired this cycle.
  always_comb begin
    wb_mask = '0;
    if (bus.wb_valid) wb_mask[bus.wb_addr] = 1'b1;
  end

  // Pending view of the scoreboard used by the hazard check.
`ifdef DECODE_WB_BYPASS_EN
  assign sb_pend = sb_q & ~wb_mask;
`else
  assign sb_pend = sb_q;
`endif

  // RAW on either read port, WAW on the destination. In debug mode an
  // illegal opcode is held off by treating it as a permanent hazard.
  always_comb begin
    hazard = bus.in_valid & ((reads_a & sb_pend[f_ra]) |
                             (reads_b & sb_pend[f_rb]) |
                             (writes  & sb_pend[f_rd]));
    if (ILLEGAL_AS_NOP == 0)
      hazard = hazard | (bus.in_valid & is_illegal);
  end

  assign in_ready = (~out_valid_q | bus.out_ready) & ~hazard & ~bus.flush;
  assign accept   = bus.in_valid & in_ready;

  // Output register and scoreboard next state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_rd_d    = out_rd_q;
    rega_d      = rega_q;
    regb_d      = regb_q;
    out_imm_d   = out_imm_q;
    out_we_d    = out_we_q;
    illegal_d   = accept & is_illegal;

    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_op_d    = is_illegal ? 4'h0 : f_op;
      out_rd_d    = f_rd;
      rega_d      = reads_a ? f_ra : 4'h0;
      regb_d      = reads_b ? f_rb : 4'h0;
      out_imm_d   = f_imm;
      out_we_d    = writes;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clears first, then the set, so a same-index set overrides a clear.
    sb_d = sb_q & ~wb_mask;
    // A flushed writer never reaches writeback; WAW stalling makes it the
    // only pending writer of its destination, so its bit can be dropped.
    if (bus.flush && out_valid_q && out_we_q)
      sb_d[out_rd_q] = 1'b0;
    if (accept && writes)
      sb_d[f_rd] = 1'b1;
  end

  // Registered stage boundary toward execute.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_op_q    <= 4'h0;
      out_rd_q    <= 4'h0;
      rega_q      <= 4'h0;
      regb_q      <= 4'h0;
      out_imm_q   <= 8'h00;
      out_we_q    <= 1'b0;
      illegal_q   <= 1'b0;
      sb_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_rd_q    <= out_rd_d;
      rega_q      <= rega_d;
      regb_q      <= regb_d;
      out_imm_q   <= out_imm_d;
      out_we_q    <= out_we_d;
      illegal_q   <= illegal_d;
      sb_q        <= sb_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_op    = out_op_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.rega_addr = rega_q;
  assign bus.regb_addr = regb_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.out_we    = out_we_q;
  assign bus.illegal   = illegal_q;
  assign bus.busy      = |sb_q;

endmodule
